// File: rtl/pipe_seq_ctrl.sv
// Pipeline sequencer: steers PC/IR enables, flushes and stalls for jumps, loads and halt.
// Optional stall counter is built when PIPE_SEQ_STALL_CNT_EN is defined.
module pipe_seq_ctrl (
   input  logic        clk,
   input  logic        reset,
   input  logic [23:0] ins,
   input  logic        ext_hold,
   output logic        pc_en,
   output logic        ir_load,
   output logic        flush,
   output logic        stall,
   output logic        halted,
   output logic [15:0] stall_cnt
);

   typedef enum logic [2:0] {
      RUN  = 3'd0,
      JMP1 = 3'd1,
      JMP2 = 3'd2,
      LDW  = 3'd3,
      HALT = 3'd4
   } state_t;

   state_t     state_q, state_d;
   logic       ld_seen_q, ld_seen_d;
   logic [3:0] opcode;
   logic       holdActive;

   assign opcode     = ins[23:20];
   assign holdActive = ext_hold && (state_q != HALT);

   always_comb begin
      state_d   = state_q;
      ld_seen_d = ld_seen_q;
      if (!holdActive) begin
         // ld_seen lives exactly one cycle: the RUN cycle right after a load wait
         ld_seen_d = (state_q == LDW);
         unique case (state_q)
            RUN: begin
               if (opcode == 4'hA)
                  state_d = JMP1;
               else if (opcode == 4'hF)
                  state_d = HALT;
               else if (opcode == 4'h8 && ins[19] && !ld_seen_q)
                  state_d = LDW;
               else
                  state_d = RUN;
            end
            JMP1:    state_d = JMP2;
            JMP2:    state_d = RUN;
            LDW:     state_d = RUN;
            HALT:    state_d = HALT;
            default: state_d = RUN;
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= RUN;
         ld_seen_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         ld_seen_q <= ld_seen_d;
      end
   end

   always_comb begin
      pc_en   = 1'b1;
      ir_load = 1'b1;
      flush   = 1'b0;
      stall   = 1'b0;
      halted  = 1'b0;
      unique case (state_q)
         RUN: ;
         JMP1, JMP2: begin
            flush = 1'b1;
            stall = 1'b1;
         end
         LDW: begin
            pc_en   = 1'b0;
            ir_load = 1'b0;
            stall   = 1'b1;
         end
         HALT: begin
            pc_en   = 1'b0;
            ir_load = 1'b0;
            stall   = 1'b1;
            halted  = 1'b1;
         end
         default: ;
      endcase
      // A held pipeline freezes fetch but leaves any pending flush visible
      if (holdActive) begin
         pc_en   = 1'b0;
         ir_load = 1'b0;
         stall   = 1'b1;
      end
   end

`ifdef PIPE_SEQ_STALL_CNT_EN
   logic [15:0] stall_cnt_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         stall_cnt_q <= 16'h0000;
      else if (stall && (stall_cnt_q != 16'hFFFF))
         stall_cnt_q <= stall_cnt_q + 16'd1;
   end

   assign stall_cnt = stall_cnt_q;
`else
   assign stall_cnt = 16'h0000;
`endif

   logic unusedInsBits;
   assign unusedInsBits = ^ins[18:0];

endmodule

// File: tb/tb_pipe_seq_ctrl.sv
// Table-driven bench for pipe_seq_ctrl: expected outputs are queued when a row is driven
// and popped when the DUT outputs are sampled mid-cycle.
module tb_pipe_seq_ctrl;

   logic        clk;
   logic        reset;
   logic [23:0] ins;
   logic        ext_hold;
   logic        pc_en, ir_load, flush, stall, halted;
   logic [15:0] stall_cnt;

   pipe_seq_ctrl dut (
      .clk       (clk),
      .reset     (reset),
      .ins       (ins),
      .ext_hold  (ext_hold),
      .pc_en     (pc_en),
      .ir_load   (ir_load),
      .flush     (flush),
      .stall     (stall),
      .halted    (halted),
      .stall_cnt (stall_cnt)
   );

   // outs = {pc_en, ir_load, flush, stall, halted}
   localparam logic [4:0] O_RUN  = 5'b11000;
   localparam logic [4:0] O_GATE = 5'b00010;
   localparam logic [4:0] O_JMP  = 5'b11110;
   localparam logic [4:0] O_JMPH = 5'b00110;
   localparam logic [4:0] O_LDW  = 5'b00010;
   localparam logic [4:0] O_HALT = 5'b00011;

   typedef struct packed {
      logic        rst;
      logic [23:0] ins;
      logic        hold;
      logic [4:0]  outs;
      logic [15:0] cnt;
   } vec_t;

   typedef struct packed {
      logic [4:0]  outs;
      logic [15:0] cnt;
   } out_t;

   vec_t tbl[$];
   out_t expQ[$];
   int   vectorCount = 0;
   int   missCount   = 0;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Counter column is written for the counting build; the plain build always reads zero
   function automatic logic [15:0] expCnt(input logic [15:0] v);
`ifdef PIPE_SEQ_STALL_CNT_EN
      return v;
`else
      return 16'h0000;
`endif
   endfunction

   task automatic addVec(input logic r, input logic [23:0] i, input logic h,
                         input logic [4:0] o, input logic [15:0] c);
      vec_t v;
      v.rst  = r;
      v.ins  = i;
      v.hold = h;
      v.outs = o;
      v.cnt  = c;
      tbl.push_back(v);
   endtask

   task automatic applyStimulus(input vec_t v);
      out_t e;
      @(posedge clk);
      #1;
      reset    = v.rst;
      ins      = v.ins;
      ext_hold = v.hold;
      e.outs   = v.outs;
      e.cnt    = expCnt(v.cnt);
      expQ.push_back(e);
   endtask

   task automatic checkOutput(input int idx);
      out_t e;
      out_t a;
      #3;
      e = expQ.pop_front();
      a.outs = {pc_en, ir_load, flush, stall, halted};
      a.cnt  = stall_cnt;
      vectorCount++;
      if (a !== e) begin
         missCount++;
         $display("[TB] FAIL vec %0d: got pc/ir/fl/st/hl=%b cnt=%h, want %b cnt=%h",
                  idx, a.outs, a.cnt, e.outs, e.cnt);
      end
   endtask

   task automatic idleCycle(input logic [23:0] i, input logic h);
      @(posedge clk);
      #1;
      reset    = 1'b0;
      ins      = i;
      ext_hold = h;
   endtask

   initial begin
      vec_t v;
      int   longWait;

      reset    = 1'b1;
      ins      = 24'h000000;
      ext_hold = 1'b0;

      // Reset values, hold gating during reset, idle RUN
      addVec(1, 24'h000000, 0, O_RUN,  0);
      addVec(1, 24'h000000, 1, O_GATE, 0);
      for (int k = 0; k < 5; k++) addVec(0, 24'h000000, 0, O_RUN, 0);
      // Jump: two flush/stall cycles
      addVec(0, 24'hA00000, 0, O_RUN,  0);
      addVec(0, 24'h000000, 0, O_JMP,  0);
      addVec(0, 24'h000000, 0, O_JMP,  1);
      addVec(0, 24'h000000, 0, O_RUN,  2);
      // Load held three cycles: single wait, no re-stall
      addVec(0, 24'h880000, 0, O_RUN,  2);
      addVec(0, 24'h880000, 0, O_LDW,  2);
      addVec(0, 24'h880000, 0, O_RUN,  3);
      addVec(0, 24'h000000, 0, O_RUN,  3);
      // Non-stalling opcodes
      addVec(0, 24'h800000, 0, O_RUN,  3);
      addVec(0, 24'h3FFFFF, 0, O_RUN,  3);
      addVec(0, 24'h000000, 0, O_RUN,  3);
      // Hold in RUN blocks decode
      addVec(0, 24'hA00000, 1, O_GATE, 3);
      addVec(0, 24'hF00000, 1, O_GATE, 4);
      addVec(0, 24'h000000, 0, O_RUN,  5);
      // Hold during JMP1
      addVec(1, 24'h000000, 0, O_RUN,  0);
      addVec(0, 24'hA00000, 0, O_RUN,  0);
      addVec(0, 24'h000000, 1, O_JMPH, 0);
      addVec(0, 24'h000000, 1, O_JMPH, 1);
      addVec(0, 24'h000000, 1, O_JMPH, 2);
      addVec(0, 24'h000000, 0, O_JMP,  3);
      addVec(0, 24'h000000, 0, O_JMP,  4);
      addVec(0, 24'h000000, 0, O_RUN,  5);
      // Hold during LDW and during the ld_seen cycle
      addVec(0, 24'h880000, 0, O_RUN,  5);
      addVec(0, 24'h880000, 1, O_LDW,  5);
      addVec(0, 24'h880000, 0, O_LDW,  6);
      addVec(0, 24'h880000, 1, O_GATE, 7);
      addVec(0, 24'h880000, 0, O_RUN,  8);
      addVec(0, 24'h000000, 0, O_RUN,  8);
      // Hold during JMP2
      addVec(0, 24'hA00000, 0, O_RUN,  8);
      addVec(0, 24'h000000, 0, O_JMP,  8);
      addVec(0, 24'h000000, 1, O_JMPH, 9);
      addVec(0, 24'h000000, 0, O_JMP,  10);
      addVec(0, 24'h000000, 0, O_RUN,  11);
      // Async reset mid-jump and mid-load
      addVec(0, 24'hA00000, 0, O_RUN,  11);
      addVec(1, 24'h000000, 0, O_RUN,  0);
      addVec(0, 24'h000000, 0, O_RUN,  0);
      addVec(0, 24'h880000, 0, O_RUN,  0);
      addVec(1, 24'h000000, 0, O_RUN,  0);
      addVec(0, 24'h000000, 0, O_RUN,  0);
      // Halt ignores ins/hold for 10 cycles, reset recovers
      addVec(0, 24'hF00000, 0, O_RUN,  0);
      for (int k = 0; k < 10; k++)
         addVec(0, (k % 3 == 0) ? 24'hA00000 : ((k % 3 == 1) ? 24'h880000 : 24'h000000),
                k[0], O_HALT, 16'(k));
      addVec(1, 24'h000000, 0, O_RUN,  0);
      addVec(0, 24'h000000, 0, O_RUN,  0);
      addVec(0, 24'hA00000, 0, O_RUN,  0);
      addVec(0, 24'h000000, 0, O_JMP,  0);

      for (int i = 0; i < tbl.size(); i++) begin
         applyStimulus(tbl[i]);
         checkOutput(i);
      end

      // Long halt to drive the counter into saturation, then async clear
`ifdef PIPE_SEQ_STALL_CNT_EN
      longWait = 65540;
`else
      longWait = 20;
`endif
      v = '{rst: 1'b1, ins: 24'h000000, hold: 1'b0, outs: O_RUN, cnt: 16'h0000};
      applyStimulus(v);
      checkOutput(1000);
      v = '{rst: 1'b0, ins: 24'hF00000, hold: 1'b0, outs: O_RUN, cnt: 16'h0000};
      applyStimulus(v);
      checkOutput(1001);
      for (int k = 0; k < longWait; k++)
         idleCycle(24'($urandom()), 1'($urandom_range(0, 1)));
      v = '{rst: 1'b0, ins: 24'hA00000, hold: 1'b1, outs: O_HALT, cnt: 16'hFFFF};
      applyStimulus(v);
      checkOutput(1002);
      v = '{rst: 1'b0, ins: 24'h000000, hold: 1'b0, outs: O_HALT, cnt: 16'hFFFF};
      applyStimulus(v);
      checkOutput(1003);
      v = '{rst: 1'b1, ins: 24'h000000, hold: 1'b0, outs: O_RUN, cnt: 16'h0000};
      applyStimulus(v);
      checkOutput(1004);
      v = '{rst: 1'b0, ins: 24'h000000, hold: 1'b0, outs: O_RUN, cnt: 16'h0000};
      applyStimulus(v);
      checkOutput(1005);

      $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
      $finish;
   end

endmodule

// File: doc/pipe_seq_ctrl.md
PIPE_SEQ_CTRL -- requirements
Module: pipe_seq_ctrl

Interface
REQ-001 SHALL have port clk, input, 1, single clock; all state updates on rising edge.
REQ-002 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-003 SHALL have port ins, input, 24, instruction in decode stage; opcode = ins[23:20].
REQ-004 SHALL have port ext_hold, input, 1, external hold request (memory busy).
REQ-005 SHALL have port pc_en, output, 1, program-counter advance enable.
REQ-006 SHALL have port ir_load, output, 1, instruction-register load enable.
REQ-007 SHALL have port flush, output, 1, force NOP into decode stage.
REQ-008 SHALL have port stall, output, 1, pipeline stalled this cycle.
REQ-009 SHALL have port halted, output, 1, processor halted.
REQ-010 SHALL have port stall_cnt, output, 16, count of stalled cycles.

Function
REQ-011 SHALL implement states RUN, JMP1, JMP2, LDW, HALT in a registered state register.
REQ-012 SHALL decode ins only in RUN with ext_hold=0: opcode 4'hA -> JMP1; 4'hF -> HALT; 4'h8 with ins[19]=1 and ld_seen=0 -> LDW; else stay RUN.
REQ-013 SHALL transition JMP1 -> JMP2 -> RUN and LDW -> RUN unconditionally when ext_hold=0, ignoring ins.
REQ-014 SHALL remain in HALT until reset; ext_hold and ins have no effect in HALT.
REQ-015 SHALL hold the current state while ext_hold=1 in RUN, JMP1, JMP2 or LDW.
REQ-016 SHALL drive Moore outputs: RUN pc_en=1 ir_load=1 flush=0 stall=0; JMP1/JMP2 pc_en=1 ir_load=1 flush=1 stall=1; LDW pc_en=0 ir_load=0 flush=0 stall=1; HALT all 0 except stall=1 halted=1.
REQ-017 SHALL, when ext_hold=1 outside HALT, combinationally force pc_en=0, ir_load=0, stall=1 while keeping flush at its state value.
REQ-018 SHALL set 1-bit flag ld_seen on the LDW->RUN transition and clear it on the next cycle, so the same load instruction is not re-stalled.
REQ-019 SHALL keep ld_seen unchanged while ext_hold=1.
REQ-020 SHALL make state outputs effective the cycle after the decoding edge (1-cycle latency from ins to pc_en/flush change).
REQ-021 SHALL treat all opcodes other than 4'hA, 4'hF and load as single-cycle (no stall).

Reset
REQ-022 SHALL on reset=1, asynchronously and from any state including mid-jump or mid-load, force state=RUN, ld_seen=0, stall_cnt=0.
REQ-023 SHALL present during reset pc_en=1, ir_load=1, flush=0, stall=0, halted=0 (ext_hold gating still applies).

Configuration
REQ-024 SHALL, with macro PIPE_SEQ_STALL_CNT_EN defined, increment stall_cnt by 1 on each rising edge where stall=1, saturating at 16'hFFFF.
REQ-025 SHALL, without PIPE_SEQ_STALL_CNT_EN, drive stall_cnt constant 16'h0000 with no counter register.

Verification
REQ-026 SHALL cover: reset released, ins=24'h000000 for 5 cycles -> pc_en=1, stall=0 each cycle, stall_cnt=0.
REQ-027 SHALL cover: ins=24'hA00000 for 1 cycle in RUN -> next 2 cycles flush=1, stall=1, then RUN; stall_cnt=2.
REQ-028 SHALL cover: ins=24'h880000 held 3 cycles -> exactly one LDW cycle with pc_en=0, then RUN with no re-stall; stall_cnt +1.
REQ-029 SHALL cover: ins=24'hF00000 -> halted=1, pc_en=0 held 10 cycles regardless of ins/ext_hold; reset pulse -> RUN, halted=0.
REQ-030 SHALL cover: ext_hold=1 for 3 cycles during JMP1 -> state held, pc_en=0, flush=1; then JMP2, RUN; stall_cnt=5.
REQ-031 SHALL cover: reset asserted mid-JMP1 and stall_cnt preloaded to 16'hFFFF via long halt -> immediate RUN outputs, stall_cnt=0; saturation observed before reset.
